button_conditioner: RTL and testbench



---
 rtl/button_conditioner.sv | 166 ++++++++++++++++
 tb/tb_button_conditioner.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// button_conditioner
//   Conditions raw active-low push buttons for the NIOS button PIO. Each
//   channel has a two-flop synchronizer, a counter debouncer and registered
//   press/release pulses.
//
//   Optional feature macro: BUTTON_AUTO_REPEAT_EN
//     When defined, a held button re-fires press_pulse after REPEAT_DELAY
//     cycles and then every REPEAT_PERIOD cycles until released.
//
// Ports
//   clk            system clock
//   reset_n        asynchronous active-low reset
//   buttons_raw_n  [N_BUTTONS] raw pad inputs, active-low, async to clk
//   buttons_db_n   [N_BUTTONS] debounced level, active-low (to PIO)
//   press_pulse    [N_BUTTONS] one-cycle pulse per accepted press / repeat
//   release_pulse  [N_BUTTONS] one-cycle pulse per accepted release

// One independent button channel.
module button_channel #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw_n,
    output logic db_n,
    output logic press_pulse,
    output logic release_pulse
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_param
        $error("button_channel: DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD must be >= 2");
    end

    logic          sync1, sync2;
    logic [CW-1:0] cnt;
    logic          accept, press_acc, release_acc;
    logic          repeat_fire;

    // A level change is accepted on the cycle the mismatch has been seen
    // DEBOUNCE_CYCLES times in a row.
    assign accept      = (sync2 != db_n) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
    assign press_acc   = accept && !sync2;
    assign release_acc = accept &&  sync2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1         <= 1'b1;
            sync2         <= 1'b1;
            db_n          <= 1'b1;
            cnt           <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            sync1 <= raw_n;
            sync2 <= sync1;
            if (sync2 == db_n) begin
                cnt <= '0;
            end else if (accept) begin
                db_n <= sync2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            press_pulse   <= press_acc | repeat_fire;
            release_pulse <= release_acc;
        end
    end

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_t;

    rpt_state_t    state, state_nxt;
    logic [RW-1:0] rcnt, rcnt_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            rcnt  <= '0;
        end else begin
            state <= state_nxt;
            rcnt  <= rcnt_nxt;
        end
    end

    // An accepted release always wins over a repeat landing on the same cycle.
    always_comb begin
        state_nxt   = state;
        rcnt_nxt    = rcnt;
        repeat_fire = 1'b0;
        case (state)
            IDLE: begin
                if (press_acc) begin
                    state_nxt = DELAY;
                    rcnt_nxt  = '0;
                end
            end
            DELAY: begin
                if (release_acc) begin
                    state_nxt = IDLE;
                    rcnt_nxt  = '0;
                end else if (rcnt == RW'(REPEAT_DELAY - 1)) begin
                    state_nxt   = REPEAT;
                    rcnt_nxt    = '0;
                    repeat_fire = 1'b1;
                end else begin
                    rcnt_nxt = rcnt + 1'b1;
                end
            end
            REPEAT: begin
                if (release_acc) begin
                    state_nxt = IDLE;
                    rcnt_nxt  = '0;
                end else if (rcnt == RW'(REPEAT_PERIOD - 1)) begin
                    rcnt_nxt    = '0;
                    repeat_fire = 1'b1;
                end else begin
                    rcnt_nxt = rcnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                rcnt_nxt  = '0;
            end
        endcase
    end
`else
    assign repeat_fire = 1'b0;
`endif

endmodule

module button_conditioner #(
    parameter int N_BUTTONS       = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N_BUTTONS-1:0] buttons_raw_n,
    output logic [N_BUTTONS-1:0] buttons_db_n,
    output logic [N_BUTTONS-1:0] press_pulse,
    output logic [N_BUTTONS-1:0] release_pulse
);
    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk           (clk),
            .reset_n       (reset_n),
            .raw_n         (buttons_raw_n[i]),
            .db_n          (buttons_db_n[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=8,
// REPEAT_DELAY=20, REPEAT_PERIOD=5, N_BUTTONS=4. Inputs change 1 time unit
// after a rising edge; outputs are sampled at the same point.
module tb_button_conditioner;
    localparam int N = 4;
`ifdef BUTTON_AUTO_REPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n;
    logic [N-1:0] raw;
    logic [N-1:0] db_n, press, rel;

    int errors = 0;
    int checks = 0;
    int pcnt [N];
    int snap;

    button_conditioner #(
        .N_BUTTONS       (N),
        .DEBOUNCE_CYCLES (8),
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (5)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .buttons_raw_n (raw),
        .buttons_db_n  (db_n),
        .press_pulse   (press),
        .release_pulse (rel)
    );

    always #5 clk = ~clk;

    initial for (int i = 0; i < N; i++) pcnt[i] = 0;
    always @(negedge clk) for (int i = 0; i < N; i++) if (press[i] === 1'b1) pcnt[i]++;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset with all buttons held down.
        reset_n = 1'b0;
        raw     = 4'b0000;
        tick(3);
        chk("rst_db", 32'(db_n), 32'hF);
        chk("rst_press", 32'(press), 32'h0);
        chk("rst_rel", 32'(rel), 32'h0);
        reset_n = 1'b1;
        tick(9);
        chk("post_rst_e9_db", 32'(db_n), 32'hF);
        chk("post_rst_e9_press", 32'(press), 32'h0);
        tick(1);
        chk("post_rst_e10_db", 32'(db_n), 32'h0);
        chk("post_rst_e10_press", 32'(press), 32'hF);
        tick(1);
        chk("post_rst_e11_press", 32'(press), 32'h0);
        raw = 4'b1111;
        tick(9);
        chk("all_rel_e9_db", 32'(db_n), 32'h0);
        tick(1);
        chk("all_rel_e10_db", 32'(db_n), 32'hF);
        chk("all_rel_e10_rel", 32'(rel), 32'hF);
        chk("all_rel_e10_press", 32'(press), 32'h0);
        tick(1);
        chk("all_rel_e11_rel", 32'(rel), 32'h0);

        // Clean press and release on channel 0.
        raw = 4'b1110;
        tick(9);
        chk("c0_e9_db", 32'(db_n), 32'hF);
        tick(1);
        chk("c0_e10_db", 32'(db_n), 32'hE);
        chk("c0_e10_press", 32'(press), 32'h1);
        tick(1);
        chk("c0_e11_press", 32'(press), 32'h0);
        raw = 4'b1111;
        tick(9);
        chk("c0r_e9_db", 32'(db_n), 32'hE);
        chk("c0r_e9_rel", 32'(rel), 32'h0);
        tick(1);
        chk("c0r_e10_db", 32'(db_n), 32'hF);
        chk("c0r_e10_rel", 32'(rel), 32'h1);
        tick(1);
        chk("c0r_e11_rel", 32'(rel), 32'h0);

        // Bouncing channel 1: runs of 3 never qualify, then settle low.
        snap = pcnt[1];
        for (int i = 0; i < 12; i++) begin
            raw[1] = ~raw[1];
            tick(3);
        end
        chk("bounce_no_press", 32'(pcnt[1] - snap), 32'd0);
        chk("bounce_db", 32'(db_n), 32'hF);
        raw[1] = 1'b0;
        tick(9);
        chk("bounce_e9_db", 32'(db_n), 32'hF);
        tick(1);
        chk("bounce_e10_db", 32'(db_n), 32'hD);
        chk("bounce_e10_press", 32'(press), 32'h2);
        tick(1);
        chk("bounce_one_press", 32'(pcnt[1] - snap), 32'd1);
        raw = 4'b1111;
        tick(10);
        chk("bounce_rel", 32'(rel), 32'h2);
        tick(1);

        // 7-cycle glitch is one short of acceptance.
        snap = pcnt[1];
        raw[1] = 1'b0;
        tick(7);
        raw[1] = 1'b1;
        tick(12);
        chk("glitch_db", 32'(db_n), 32'hF);
        chk("glitch_no_press", 32'(pcnt[1] - snap), 32'd0);

        // Channels 1 and 3 together.
        raw = 4'b0101;
        tick(9);
        chk("sim_e9_press", 32'(press), 32'h0);
        tick(1);
        chk("sim_e10_press", 32'(press), 32'hA);
        chk("sim_e10_db", 32'(db_n), 32'h5);
        tick(1);
        chk("sim_e11_press", 32'(press), 32'h0);
        raw = 4'b1111;
        tick(10);
        chk("sim_rel", 32'(rel), 32'hA);
        chk("sim_rel_db", 32'(db_n), 32'hF);
        tick(1);

        // Channel 2 held; release accepted at t0+27.
        raw = 4'b1011;
        tick(10);
        chk("ar1_t0_press", 32'(press), 32'h4);
        for (int k = 1; k <= 35; k++) begin
            tick(1);
            chk($sformatf("ar1_press_t%0d", k), 32'(press[2]), 32'(AR && (k == 20 || k == 25)));
            chk($sformatf("ar1_rel_t%0d", k), 32'(rel[2]), 32'(k == 27));
            if (k == 17) raw = 4'b1111;
        end

        // Channel 2 held for a long time; release coincides with a repeat slot.
        raw = 4'b1011;
        tick(10);
        chk("ar2_t0_press", 32'(press), 32'h4);
        for (int k = 1; k <= 55; k++) begin
            tick(1);
            chk($sformatf("ar2_press_t%0d", k), 32'(press[2]),
                32'(AR && k >= 20 && ((k - 20) % 5) == 0));
        end
        raw = 4'b1111;
        tick(10);
        chk("ar2_t65_rel", 32'(rel), 32'h4);
        chk("ar2_t65_press", 32'(press), 32'h0);
        tick(10);

        // Reset in the middle of a debounce.
        raw = 4'b1110;
        tick(5);
        reset_n = 1'b0;
        #1;
        chk("rstdb_db", 32'(db_n), 32'hF);
        chk("rstdb_press", 32'(press), 32'h0);
        tick(3);
        reset_n = 1'b1;
        tick(9);
        chk("rstdb_e9_press", 32'(press), 32'h0);
        chk("rstdb_e9_db", 32'(db_n), 32'hF);
        tick(1);
        chk("rstdb_e10_press", 32'(press), 32'h1);
        raw = 4'b1111;
        tick(10);
        chk("rstdb_rel", 32'(rel), 32'h1);
        tick(1);

        // Reset while channel 2 is past its first repeat.
        raw = 4'b1011;
        tick(10);
        chk("rstar_t0_press", 32'(press), 32'h4);
        tick(22);
        reset_n = 1'b0;
        #1;
        chk("rstar_db", 32'(db_n), 32'hF);
        chk("rstar_press", 32'(press), 32'h0);
        chk("rstar_rel", 32'(rel), 32'h0);
        tick(3);
        reset_n = 1'b1;
        snap = pcnt[2];
        tick(9);
        chk("rstar_quiet", 32'(pcnt[2] - snap), 32'd0);
        chk("rstar_e9_db", 32'(db_n), 32'hF);
        tick(1);
        chk("rstar_e10_press", 32'(press), 32'h4);
        raw = 4'b1111;
        tick(10);
        chk("rstar_rel_pulse", 32'(rel), 32'h4);
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
